// File: rtl/mmio_map_pkg.sv
// MMIO address map shared by bus initiators: coprocessor select and register
// codes, the address-build helper, the copy-step record and the frame-master
// FSM state type.
package mmio_map_pkg;

  localparam int COPROC_BIT = 12;

  localparam logic [4:0] SEL_PHYS_P1 = 5'd0;
  localparam logic [4:0] SEL_PHYS_P2 = 5'd1;
  localparam logic [4:0] SEL_CTRL_P1 = 5'd4;
  localparam logic [4:0] SEL_CTRL_P2 = 5'd5;
  localparam logic [4:0] SEL_VGA_P1  = 5'd8;
  localparam logic [4:0] SEL_VGA_P2  = 5'd9;
  localparam logic [4:0] SEL_STAGE   = 5'd10;

  localparam logic [4:0] REG_POS = 5'd0;
  localparam logic [4:0] REG_WH  = 5'd1;

  // Where a read lands, or where a write takes its data from
  typedef enum logic [1:0] {SRC_P1, SRC_P2, SRC_WH1, SRC_WH2} src_t;

  typedef struct packed {
    logic        is_write;
    logic [12:0] address;
    src_t        src;
  } step_t;

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} state_t;

  function automatic logic [12:0] mmio_addr(input logic [4:0] sel, input logic [4:0] spec);
    logic [12:0] a;
    a = {1'b0, sel, spec, 2'b00};
    a[COPROC_BIT] = 1'b1;
    return a;
  endfunction

  function automatic step_t make_step(input logic is_write, input logic [4:0] sel,
                                      input logic [4:0] spec, input src_t src);
    step_t s;
    s.is_write = is_write;
    s.address  = mmio_addr(sel, spec);
    s.src      = src;
    return s;
  endfunction

endpackage

// File: rtl/mmio_frame_master_if.sv
// MMIO initiator bus bundle: request/grant to the arbiter plus the
// address/data/write-strobe path to the slaves.
interface mmio_frame_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [12:0] address;
  logic [31:0] wr_data;
  logic        wren;
  logic [31:0] rd_data;

  modport master (output bus_req, address, wr_data, wren, input bus_gnt, rd_data);
  modport slave  (input bus_req, address, wr_data, wren, output bus_gnt, rd_data);
endinterface

// File: rtl/mmio_step_rom.sv
// Copy-sequence step table. With MMIO_FRAME_MASTER_WH_EN defined, each player
// position write is followed by a width/height write at register offset +4.
module mmio_step_rom
  import mmio_map_pkg::*;
(
  input  logic [2:0] idx,
  output step_t      step,
  output logic       last
);

  // Decode the step index into the bus operation it performs
  always_comb begin
    step = make_step(1'b0, SEL_PHYS_P1, REG_POS, SRC_P1);
    last = 1'b0;
`ifdef MMIO_FRAME_MASTER_WH_EN
    case (idx)
      3'd0: step = make_step(1'b0, SEL_PHYS_P1, REG_POS, SRC_P1);
      3'd1: step = make_step(1'b1, SEL_VGA_P1,  REG_POS, SRC_P1);
      3'd2: step = make_step(1'b1, SEL_VGA_P1,  REG_WH,  SRC_WH1);
      3'd3: step = make_step(1'b0, SEL_PHYS_P2, REG_POS, SRC_P2);
      3'd4: step = make_step(1'b1, SEL_VGA_P2,  REG_POS, SRC_P2);
      3'd5: begin
        step = make_step(1'b1, SEL_VGA_P2, REG_WH, SRC_WH2);
        last = 1'b1;
      end
      default: ;
    endcase
`else
    case (idx)
      3'd0: step = make_step(1'b0, SEL_PHYS_P1, REG_POS, SRC_P1);
      3'd1: step = make_step(1'b1, SEL_VGA_P1,  REG_POS, SRC_P1);
      3'd2: step = make_step(1'b0, SEL_PHYS_P2, REG_POS, SRC_P2);
      3'd3: begin
        step = make_step(1'b1, SEL_VGA_P2, REG_POS, SRC_P2);
        last = 1'b1;
      end
      default: ;
    endcase
`endif
  end

endmodule

// File: rtl/mmio_frame_master.sv
// Frame-tick driven MMIO initiator: copies player positions from the physics
// coprocessor into the VGA coprocessor each frame, via a request/grant arbiter.
// Optional build macro MMIO_FRAME_MASTER_WH_EN adds the width/height writes.
module mmio_frame_master
  import mmio_map_pkg::*;
#(
  parameter int          READ_LAT    = 2,
  parameter int          GNT_TIMEOUT = 64,
  parameter logic [31:0] WH_P1       = 32'h0020_0040,
  parameter logic [31:0] WH_P2       = 32'h0020_0040
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_tick,
  mmio_frame_master_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [7:0]                 overrun
);

  localparam int LW = $clog2(READ_LAT) + 1;
  localparam int TW = $clog2(GNT_TIMEOUT) + 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TIMEOUT - 1);

  state_t        state;
  logic [2:0]    step;
  logic [LW-1:0] lat_cnt;
  logic [TW-1:0] tcnt;
  logic          pending;
  logic          bus_req_r, wren_r;
  logic [12:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [13:0]   pos1, pos2, pos1_byp, pos2_byp;
  logic          cap;
  step_t         cur, nxt, tgt;
  logic          cur_last, unused_nxt_last, unused_rd_hi;

  mmio_step_rom u_rom_cur (.idx(step),        .step(cur), .last(cur_last));
  mmio_step_rom u_rom_nxt (.idx(step + 3'd1), .step(nxt), .last(unused_nxt_last));

  function automatic logic [31:0] src_word(input src_t src, input logic [13:0] p1,
                                           input logic [13:0] p2);
    case (src)
      SRC_P1:  return {18'b0, p1};
      SRC_P2:  return {18'b0, p2};
      SRC_WH1: return WH_P1;
      default: return WH_P2;
    endcase
  endfunction

  // The step being loaded: step 0 on first grant, otherwise the following step
  assign tgt = (state == REQ) ? cur : nxt;
  assign unused_rd_hi = ^bus.rd_data[31:14];

  // Read capture, with bypass so a write right after its read sees fresh data
  always_comb begin
    cap      = (state == RD) && bus.bus_gnt && (lat_cnt == LAT_LAST);
    pos1_byp = pos1;
    pos2_byp = pos2;
    if (cap && cur.src == SRC_P1) pos1_byp = bus.rd_data[13:0];
    if (cap && cur.src == SRC_P2) pos2_byp = bus.rd_data[13:0];
  end

  // Position holding registers (data only, no reset)
  always_ff @(posedge clock) begin
    pos1 <= pos1_byp;
    pos2 <= pos2_byp;
  end

  // Sequencer: request, step through reads/writes, time out, track ticks
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      step      <= '0;
      lat_cnt   <= '0;
      tcnt      <= '0;
      pending   <= 1'b0;
      bus_req_r <= 1'b0;
      wren_r    <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      overrun   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick || pending) begin
            state     <= REQ;
            bus_req_r <= 1'b1;
            busy      <= 1'b1;
            pending   <= 1'b0;
            step      <= '0;
            tcnt      <= '0;
          end
        end
        REQ, RD, WR: begin
          if (!bus.bus_gnt) begin
            // Not owning the bus: hold the step, restart any read latency
            lat_cnt <= '0;
            if (tcnt == TMO_LAST) begin
              state     <= IDLE;
              err       <= 1'b1;
              bus_req_r <= 1'b0;
              busy      <= 1'b0;
              addr_r    <= '0;
              wdata_r   <= '0;
              wren_r    <= 1'b0;
              tcnt      <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end else begin
            tcnt <= '0;
            if (state == RD && lat_cnt != LAT_LAST) begin
              lat_cnt <= lat_cnt + LW'(1);
            end else if (state != REQ && cur_last) begin
              state     <= DONE;
              done      <= 1'b1;
              bus_req_r <= 1'b0;
              busy      <= 1'b0;
              err       <= 1'b0;
              addr_r    <= '0;
              wdata_r   <= '0;
              wren_r    <= 1'b0;
            end else begin
              if (state != REQ) step <= step + 3'd1;
              state   <= tgt.is_write ? WR : RD;
              addr_r  <= tgt.address;
              wren_r  <= tgt.is_write;
              wdata_r <= tgt.is_write ? src_word(tgt.src, pos1_byp, pos2_byp) : '0;
              lat_cnt <= '0;
            end
          end
          if (frame_tick) begin
            if (!pending)              pending <= 1'b1;
            else if (overrun != 8'hFF) overrun <= overrun + 8'd1;
          end
        end
        DONE: begin
          if (frame_tick && pending && overrun != 8'hFF) overrun <= overrun + 8'd1;
          if (frame_tick || pending) begin
            state     <= REQ;
            bus_req_r <= 1'b1;
            busy      <= 1'b1;
            pending   <= 1'b0;
            step      <= '0;
            tcnt      <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs are quiet whenever the grant is not held this cycle
  assign bus.bus_req = bus_req_r;
  assign bus.address = bus.bus_gnt ? addr_r  : '0;
  assign bus.wr_data = bus.bus_gnt ? wdata_r : '0;
  assign bus.wren    = bus.bus_gnt & wren_r;

endmodule
